// File: rtl/contador_decrescente_pkg.sv
// -----------------------------------------------------------------------------
// contador_decrescente_pkg
// Shared definitions for the loadable down-counter:
//   estado_t    - 2-bit state encoding. ILEGAL names the unused code so that
//                 a raw register value can always be cast to the enum.
//   DECREMENTO  - adder operand that turns "A + B" into "A - 1" on 8 bits.
// -----------------------------------------------------------------------------
package contador_decrescente_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        FIM      = 2'b10,
        ILEGAL   = 2'b11
    } estado_t;

    // Two's-complement -1 on the shared 8-bit adder.
    localparam logic [7:0] DECREMENTO = 8'hFF;

endpackage

// File: rtl/contador_decrescente_if.sv
// -----------------------------------------------------------------------------
// contador_decrescente_if
// Bundle of the counter's control and status signals.
//   Load      start request (driven by master)
//   Valor     initial count, WIDTH bits (driven by master)
//   Habilita  count enable (driven by master)
//   Q         current count, WIDTH bits (driven by slave)
//   Ocupado   high while counting (driven by slave)
//   Fim       one-cycle completion pulse (driven by slave)
// Modports: master = user of the counter, slave = the counter itself.
// -----------------------------------------------------------------------------
interface contador_decrescente_if #(
    parameter int WIDTH = 3
);
    logic             Load;
    logic [WIDTH-1:0] Valor;
    logic             Habilita;
    logic [WIDTH-1:0] Q;
    logic             Ocupado;
    logic             Fim;

    modport master (
        output Load, Valor, Habilita,
        input  Q, Ocupado, Fim
    );

    modport slave (
        input  Load, Valor, Habilita,
        output Q, Ocupado, Fim
    );
endinterface

// File: rtl/contador_decrescente_logica_proximo_estado_dec.sv
// -----------------------------------------------------------------------------
// logica_proximo_estado_dec
// Combinational core of the down-counter: next state, Q mux (hold / load /
// decrement) and output decode from the registered state.
//   estado_q_i  current state
//   q_q_i       current count
//   q_dec_i     current count minus one (from the adder)
//   load_i, valor_i, habilita_i  handshake inputs
//   estado_d_o  next state
//   q_d_o       next count
//   ocupado_o   decoded from state only
//   fim_o       decoded from state only
// -----------------------------------------------------------------------------
module logica_proximo_estado_dec
    import contador_decrescente_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  estado_t          estado_q_i,
    input  logic [WIDTH-1:0] q_q_i,
    input  logic [WIDTH-1:0] q_dec_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] valor_i,
    input  logic             habilita_i,
    output estado_t          estado_d_o,
    output logic [WIDTH-1:0] q_d_o,
    output logic             ocupado_o,
    output logic             fim_o
);
    always_comb begin
        estado_d_o = estado_q_i;
        q_d_o      = q_q_i;
        ocupado_o  = 1'b0;
        fim_o      = 1'b0;

        case (estado_q_i)
            OCIOSO: begin
                if (load_i) begin
                    q_d_o = valor_i;
                    // A zero load has nothing to count: finish straight away.
                    estado_d_o = (valor_i == '0) ? FIM : CONTANDO;
                end
            end
            CONTANDO: begin
                ocupado_o = 1'b1;
                if (habilita_i) begin
                    q_d_o = q_dec_i;
                    if (q_q_i == WIDTH'(1)) begin
                        estado_d_o = FIM;
                    end
                end
            end
            FIM: begin
                fim_o      = 1'b1;
                estado_d_o = OCIOSO;
            end
            default: begin
                // Unused encoding recovers to idle on the next edge.
                estado_d_o = OCIOSO;
            end
        endcase
    end
endmodule

// File: rtl/flipflopd.sv
// -----------------------------------------------------------------------------
// FlipFlopD
// W-bit D register, rising-edge clocked, asynchronous active-low clear.
//   Clk    clock
//   Reset  0 clears Q immediately
//   D      next value
//   Q      registered value
// -----------------------------------------------------------------------------
module FlipFlopD #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Q <= '0;
        end else begin
            Q <= D;
        end
    end
endmodule

// File: rtl/somador8bits.sv
// -----------------------------------------------------------------------------
// Somador8Bits
// Combinational 8-bit adder with carry in and carry out.
//   A, B   operands
//   Cin    carry in
//   S      sum
//   Cout   carry out
// -----------------------------------------------------------------------------
module Somador8Bits (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);
    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
endmodule

// File: rtl/contador_decrescente.sv
// -----------------------------------------------------------------------------
// contador_decrescente
// Loadable synchronous down-counter with start/busy/done handshake, used as a
// programmable delay / timeout element.
//   Clk    system clock, rising edge
//   Reset  asynchronous active-low clear
//   bus    slave side of contador_decrescente_if (Load, Valor, Habilita in;
//          Q, Ocupado, Fim out)
// WIDTH must lie in 1..8 since the decrement runs on the 8-bit adder.
// -----------------------------------------------------------------------------
module contador_decrescente
    import contador_decrescente_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    contador_decrescente_if.slave bus
);
    logic [1:0]       estado_bits_q;
    estado_t          estado_q;
    estado_t          estado_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [7:0]       soma;
    logic             unused_carry;

    FlipFlopD #(.W(2)) u_ff_estado (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (estado_d),
        .Q     (estado_bits_q)
    );

    assign estado_q = estado_t'(estado_bits_q);

    FlipFlopD #(.W(WIDTH)) u_ff_q (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (q_d),
        .Q     (q_q)
    );

    // Q - 1 = Q + 0xFF (mod 256); only the low WIDTH bits matter.
    Somador8Bits u_somador (
        .A    (8'(q_q)),
        .B    (DECREMENTO),
        .Cin  (1'b0),
        .S    (soma),
        .Cout (unused_carry)
    );

    generate
        if (WIDTH < 8) begin : g_alto
            logic [7-WIDTH:0] unused_alto;
            assign unused_alto = soma[7:WIDTH];
        end
    endgenerate

    logica_proximo_estado_dec #(.WIDTH(WIDTH)) u_logica (
        .estado_q_i (estado_q),
        .q_q_i      (q_q),
        .q_dec_i    (soma[WIDTH-1:0]),
        .load_i     (bus.Load),
        .valor_i    (bus.Valor),
        .habilita_i (bus.Habilita),
        .estado_d_o (estado_d),
        .q_d_o      (q_d),
        .ocupado_o  (bus.Ocupado),
        .fim_o      (bus.Fim)
    );

    assign bus.Q = q_q;
endmodule

// File: tb/tb_contador_decrescente.sv
// -----------------------------------------------------------------------------
// tb_contador_decrescente
// Directed stimulus for contador_decrescente (WIDTH=3) with a behavioural
// model checked every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_contador_decrescente;
    localparam int WIDTH = 3;

    logic Clk;
    logic Reset;
    int   errors;
    int   checks;
    bit   cmp_on;

    contador_decrescente_if #(.WIDTH(WIDTH)) bus ();

    contador_decrescente #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: remaining count plus "counting" and "finishing" flags.
    int m_q;
    bit m_busy;
    bit m_fim;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_q = 0; m_busy = 0; m_fim = 0;
        end else if (m_fim) begin
            m_fim = 0;
        end else if (m_busy) begin
            if (bus.Habilita) begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_busy = 0; m_fim = 1;
                end
            end
        end else if (bus.Load) begin
            m_q = int'(bus.Valor);
            if (m_q == 0) m_fim = 1;
            else          m_busy = 1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (cmp_on) begin
            chk("model_Q", int'(bus.Q), m_q);
            chk("model_Ocupado", int'(bus.Ocupado), int'(m_busy));
            chk("model_Fim", int'(bus.Fim), int'(m_fim));
        end
    end

    // Drive inputs, then advance to one time unit after the next falling edge.
    task automatic tick(input bit l, input int v, input bit h);
        bus.Load     = l;
        bus.Valor    = WIDTH'(v);
        bus.Habilita = h;
        @(negedge Clk);
        #1;
    endtask

    int n_busy;
    int n_fim;
    bit hab;

    initial begin
        errors = 0; checks = 0; cmp_on = 0;
        bus.Load = 0; bus.Valor = '0; bus.Habilita = 0;
        Reset = 1;
        #1 Reset = 0;
        #20;
        chk("reset_Q", int'(bus.Q), 0);
        chk("reset_Ocupado", int'(bus.Ocupado), 0);
        chk("reset_Fim", int'(bus.Fim), 0);
        @(negedge Clk); #1;
        Reset = 1;
        cmp_on = 1;
        tick(0, 0, 1);
        chk("idle_after_release_Q", int'(bus.Q), 0);

        // Valor=5, Habilita=1: Q 5,4,3,2,1,0; Ocupado for 5 cycles; Fim on Q=0.
        n_busy = 0;
        tick(1, 5, 1);
        for (int i = 0; i <= 5; i++) begin
            chk("cnt5_Q", int'(bus.Q), 5 - i);
            chk("cnt5_Fim", int'(bus.Fim), (i == 5) ? 1 : 0);
            n_busy += int'(bus.Ocupado);
            tick(0, 0, 1);
        end
        chk("cnt5_busy_cycles", n_busy, 5);
        chk("cnt5_back_idle_Fim", int'(bus.Fim), 0);
        chk("cnt5_back_idle_Ocupado", int'(bus.Ocupado), 0);

        // Valor=0: immediate finish, never busy.
        tick(1, 0, 1);
        chk("zero_Fim", int'(bus.Fim), 1);
        chk("zero_Q", int'(bus.Q), 0);
        chk("zero_Ocupado", int'(bus.Ocupado), 0);
        tick(0, 0, 1);
        chk("zero_Fim_drop", int'(bus.Fim), 0);
        chk("zero_Ocupado_after", int'(bus.Ocupado), 0);

        // Valor=7, Habilita pattern 1,0,0 repeating: 7 counts + 12 pauses = 19.
        n_busy = 0; n_fim = 0;
        tick(1, 7, 1);
        for (int i = 0; i < 23; i++) begin
            n_busy += int'(bus.Ocupado);
            n_fim  += int'(bus.Fim);
            hab = ((i % 3) == 0);
            tick(0, 0, hab);
        end
        chk("pause_busy_cycles", n_busy, 19);
        chk("pause_fim_pulses", n_fim, 1);

        // Valor=6 with Load/Valor=2 pulsed mid-count: ignored.
        tick(1, 6, 1);
        for (int i = 0; i <= 6; i++) begin
            chk("ignore_load_Q", int'(bus.Q), 6 - i);
            tick((i == 1 || i == 3) ? 1'b1 : 1'b0, 2, 1);
        end

        // Asynchronous reset between edges while Q=4.
        tick(1, 5, 1);
        tick(0, 0, 1);
        chk("pre_reset_Q", int'(bus.Q), 4);
        #2 Reset = 0;
        #1;
        chk("async_reset_Q", int'(bus.Q), 0);
        chk("async_reset_Ocupado", int'(bus.Ocupado), 0);
        chk("async_reset_Fim", int'(bus.Fim), 0);
        @(negedge Clk); #1;
        Reset = 1;
        tick(0, 0, 1);
        chk("post_reset_idle_Q", int'(bus.Q), 0);
        tick(1, 3, 1);
        for (int i = 0; i <= 3; i++) begin
            chk("post_reset_Q", int'(bus.Q), 3 - i);
            tick(0, 0, 1);
        end

        // Load held high with Valor=1: period-3 pattern busy, done, idle.
        for (int i = 1; i <= 9; i++) begin
            tick(1, 1, 1);
            chk("hold1_Ocupado", int'(bus.Ocupado), ((i % 3) == 1) ? 1 : 0);
            chk("hold1_Fim", int'(bus.Fim), ((i % 3) == 2) ? 1 : 0);
            chk("hold1_Q", int'(bus.Q), ((i % 3) == 1) ? 1 : 0);
        end
        tick(0, 0, 1);
        tick(0, 0, 1);

        cmp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/contador_decrescente.md
Name: contador_decrescente

Overview:
- Loadable synchronous down-counter with a start/busy/done handshake.
- Complements the free-running up-counter: it counts down from a loaded value to zero, then raises a one-cycle Fim pulse.
- Serves as the programmable delay and timeout element for the control FSMs in the datapath.
- Built structurally from FlipFlopD state elements and the shared 8-bit adder.

Parameters:
- WIDTH, 3, counter width in bits; legal range 1..8 because the decrement uses the 8-bit adder.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately
- Load  input  1  start request; sampled only in state OCIOSO
- Valor  input  WIDTH  initial count, captured when Load is accepted
- Habilita  input  1  count enable; 0 pauses the count in CONTANDO
- Q  output  WIDTH  current count value
- Ocupado  output  1  1 while in state CONTANDO
- Fim  output  1  1 for exactly one cycle, while in state FIM

Behaviour:
- Reset (Reset=0, asynchronous, any time including mid-count):
  - Q=0, state=OCIOSO, Ocupado=0, Fim=0.
  - Release is synchronous to the next edge; no count occurs on the release edge unless Load=1 in OCIOSO.
- States: OCIOSO, CONTANDO, FIM. Encoding is 2 bits held in FlipFlopD; 2'b11 is illegal and returns to OCIOSO on the next edge.
- OCIOSO:
  - Q holds its value.
  - Load=1 with Valor!=0 -> Q<=Valor, go to CONTANDO.
  - Load=1 with Valor=0 -> Q<=0, go to FIM. The zero count finishes immediately; no CONTANDO cycle occurs.
  - Load=0 -> stay.
- CONTANDO:
  - Habilita=1 -> Q<=Q-1. If Q==1 at the edge, Q becomes 0 and the next state is FIM.
  - Habilita=0 -> Q holds and the state stays.
  - Load is ignored; a new Valor has no effect mid-count.
- FIM:
  - Fim=1, Q=0.
  - Next edge always returns to OCIOSO, whatever Load or Habilita are.
  - A Load held high through FIM is accepted in the following OCIOSO cycle.
- Latency: Load accepted at edge k with Valor=N>0 and Habilita held at 1:
  - Ocupado=1 from k to k+N.
  - Q=0 and Fim=1 from k+N to k+N+1.
  - Ocupado=0 and Fim=0 from k+N+1.
  - Each Habilita=0 cycle extends this by one cycle.
- Arithmetic:
  - Q-1 is computed as {zero-extended Q} + 8'hFF with Cin=0 in Somador8Bits; only S[WIDTH-1:0] is used.
  - Carry outputs are unused.
  - No underflow can occur, because decrement is never applied at Q=0.
- Outputs Ocupado and Fim are decoded from the registered state only. They are glitch-free and do not depend combinationally on the inputs.

Decomposition:
- Shared package:
  - state encoding constants: OCIOSO=2'b00, CONTANDO=2'b01, FIM=2'b10
  - constant DECREMENTO=8'hFF
- Reuse the existing Somador8Bits and FlipFlopD. No new state-element module.
- One natural sub-module: logica_proximo_estado_dec, the combinational next-state, Q-mux (hold/load/decrement) and output decode.

Test Plan:
- Reset, then WIDTH=3, Load=1 with Valor=5 for one cycle, Habilita=1 -> Q sequence 5,4,3,2,1,0; Ocupado high for 5 cycles; Fim high exactly on the cycle Q=0; then OCIOSO.
- Load=1 with Valor=0 -> next cycle Fim=1, Q=0, Ocupado never asserted; one cycle later Fim=0.
- Valor=7, Habilita toggled 1,0,0,1,... -> Q holds on Habilita=0 cycles; total CONTANDO time = 7 + number of paused cycles; Fim still a single pulse.
- Load pulsed with Valor=2 during CONTANDO of Valor=6 -> ignored; count continues 6..0 unchanged.
- Reset driven to 0 asynchronously between edges while Q=4 -> Q=0, Ocupado=0, Fim=0 immediately, without waiting for Clk; after release, Load with Valor=3 counts normally.
- Load held at 1 continuously with Valor=1 -> repeating pattern CONTANDO (Q=1), FIM (Q=0, Fim=1), OCIOSO, reload, with a period of 3 cycles.
